// File: rtl/serial_to_word.sv
// serial_to_word: collects a serial bit stream into WIDTH-bit words and hands
// each finished word to the power-of-two detector through a one-entry
// valid/ready buffer. Bit 0 of out_word is the first bit received.
module serial_to_word #(
  parameter int WIDTH = 8,
  parameter int CW    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic [0:WIDTH-1] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_count
);

  logic [CW-1:0]    cnt;
  logic [0:WIDTH-2] shift;
  logic             last_bit;
  logic             accept;
  logic             complete;
  logic             handshake;

  // Handshake decode: the input only stalls when finishing a word would
  // overwrite a buffered word that the detector has not taken yet.
  always_comb begin
    last_bit  = (cnt == CW'(WIDTH - 1));
    in_ready  = !(out_valid && !out_ready && last_bit);
    accept    = in_valid && in_ready;
    complete  = accept && !in_sof && last_bit;
    handshake = out_valid && out_ready;
  end

  // Bit assembly: sof restarts the word at bit 0, the last bit moves the
  // whole word into the output buffer, other bits land at the cursor.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      shift    <= '0;
      out_word <= '0;
    end else if (accept) begin
      if (in_sof) begin
        shift[0] <= in_bit;
        cnt      <= CW'(1);
      end else if (last_bit) begin
        out_word <= {shift, in_bit};
        cnt      <= '0;
      end else begin
        for (int i = 0; i < WIDTH - 1; i++) begin
          if (cnt == CW'(i)) begin
            shift[i] <= in_bit;
          end
        end
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Output buffer occupancy: a completion wins over a simultaneous handshake
  // so back-to-back words stream with no bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
    end else if (complete) begin
      out_valid <= 1'b1;
    end else if (handshake) begin
      out_valid <= 1'b0;
    end
  end

  // Delivered-word counter, wrapping naturally at 8 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_count <= '0;
    end else if (handshake) begin
      out_count <= out_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_serial_to_word.sv
// tb_serial_to_word: directed and random stimulus against a queue-based
// reference model; a separate monitor pops expected words on each handshake.
module tb_serial_to_word;

  localparam int WIDTH = 8;
  localparam int CW    = 5;

  logic             clock     = 1'b0;
  logic             reset     = 1'b1;
  logic             in_bit    = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_sof    = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [0:WIDTH-1] out_word;
  logic [7:0]       out_count;

  int compared   = 0;
  int mismatched = 0;

  bit               partial[$];
  logic [0:WIDTH-1] sb[$];
  logic             m_full  = 1'b0;
  logic [0:WIDTH-1] m_word  = '0;
  int               m_count = 0;

  serial_to_word #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  function automatic logic model_ready(input logic rdy);
    return !(m_full && !rdy && partial.size() == WIDTH - 1);
  endfunction

  task automatic compare_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare the DUT against the model's
  // current state, then advance the model across the coming edge.
  task automatic applyStimulus(input logic b, input logic v, input logic s,
                               input logic rdy, input logic rst);
    logic [0:WIDTH-1] w;
    logic hs;
    logic acc;
    @(negedge clock);
    in_bit = b; in_valid = v; in_sof = s; out_ready = rdy; reset = rst;
    #1;
    compare_val("in_ready",  in_ready,  model_ready(rdy));
    compare_val("out_valid", out_valid, m_full);
    compare_val("out_count", out_count, m_count);
    compare_val("out_word",  out_word,  m_word);
    if (rst) begin
      partial.delete();
      sb.delete();
      m_full  = 1'b0;
      m_word  = '0;
      m_count = 0;
    end else begin
      hs  = m_full && rdy;
      acc = v && model_ready(rdy);
      if (hs) begin
        m_count = (m_count + 1) % 256;
        m_full  = 1'b0;
      end
      if (acc) begin
        if (s) partial.delete();
        partial.push_back(b);
        if (partial.size() == WIDTH) begin
          for (int i = 0; i < WIDTH; i++) w[i] = partial[i];
          m_word = w;
          m_full = 1'b1;
          sb.push_back(w);
          partial.delete();
        end
      end
    end
  endtask

  // Explicit check of the DUT state as seen in the current cycle.
  task automatic checkOutput(input string name, input logic [WIDTH-1:0] exp_word,
                             input logic exp_valid, input logic [7:0] exp_count,
                             input logic exp_ready);
    compare_val($sformatf("%s.word", name),  out_word,  exp_word);
    compare_val($sformatf("%s.valid", name), out_valid, exp_valid);
    compare_val($sformatf("%s.count", name), out_count, exp_count);
    compare_val($sformatf("%s.ready", name), in_ready,  exp_ready);
  endtask

  // Streams the leading nbits of pat, first bit taken from the MSB.
  task automatic send_word(input logic [WIDTH-1:0] pat, input logic rdy, input int nbits);
    for (int i = WIDTH - 1; i >= WIDTH - nbits; i--) begin
      applyStimulus(pat[i], 1'b1, 1'b0, rdy, 1'b0);
    end
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: whenever the DUT offers a word that will be taken at the next
  // edge, it must match the oldest word the model produced.
  initial begin
    logic [0:WIDTH-1] exp;
    forever begin
      @(negedge clock);
      #2;
      if (!reset && out_valid && out_ready) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL sb_word: got %0h, expected no word at %0t", out_word, $time);
        end else begin
          exp = sb.pop_front();
          if (out_word !== exp) begin
            mismatched++;
            $display("[TB] FAIL sb_word: got %0h, expected %0h at %0t", out_word, exp, $time);
          end
        end
      end
    end
  end

  // Main sequence: directed scenarios, wrap test, then random traffic.
  initial begin
    logic [WIDTH-1:0] pat;
    logic b, v, s, rdy, rst;

    do_reset();
    do_reset();
    send_word(8'b10000000, 1'b1, 8);
    idle(1'b1);
    checkOutput("single_a", 8'b10000000, 1'b1, 8'd0, 1'b1);
    idle(1'b1);
    checkOutput("single_b", 8'b10000000, 1'b0, 8'd1, 1'b1);

    do_reset();
    send_word(8'b01000000, 1'b1, 8);
    send_word(8'b01011010, 1'b1, 8);
    idle(1'b1);
    checkOutput("b2b_a", 8'b01011010, 1'b1, 8'd1, 1'b1);
    idle(1'b1);
    checkOutput("b2b_b", 8'b01011010, 1'b0, 8'd2, 1'b1);

    do_reset();
    send_word(8'b00100000, 1'b0, 8);
    send_word(8'b11010000, 1'b0, 7);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("stall", 8'b00100000, 1'b1, 8'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    checkOutput("unstall", 8'b11010000, 1'b1, 8'd1, 1'b1);

    do_reset();
    send_word(8'b11100000, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    send_word(8'b00001000, 1'b1, 7);
    idle(1'b1);
    checkOutput("sof", 8'b00000100, 1'b1, 8'd0, 1'b1);

    do_reset();
    send_word(8'b00010000, 1'b0, 8);
    send_word(8'b10110110, 1'b0, 5);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1'b0);
    checkOutput("mid_reset", 8'b00000000, 1'b0, 8'd0, 1'b1);
    send_word(8'b00001000, 1'b0, 8);
    idle(1'b0);
    checkOutput("after_reset", 8'b00001000, 1'b1, 8'd0, 1'b1);

    do_reset();
    pat = '0;
    for (int n = 0; n < 255; n++) begin
      pat = WIDTH'($urandom);
      send_word(pat, 1'b1, 8);
    end
    idle(1'b1);
    idle(1'b1);
    checkOutput("wrap_255", pat, 1'b0, 8'd255, 1'b1);
    pat = WIDTH'($urandom);
    send_word(pat, 1'b1, 8);
    idle(1'b1);
    idle(1'b1);
    checkOutput("wrap_0", pat, 1'b0, 8'd0, 1'b1);

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      v   = ($urandom_range(0, 3) != 0);
      s   = v && ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      b   = 1'($urandom);
      applyStimulus(b, v, s, rdy, rst);
    end
    idle(1'b1);
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
